fifo_banked_2w: RTL

Two-wide banked FIFO: accepts 0–2 entries and releases 0–2 entries per cycle, for instruction/uop queues between pipeline stages of different widths. Storage is two single-write banks of DEPTH/2 rows. Incoming lanes are depermuted into banks by the write-pointer LSB, and outgoing lanes are permuted back into program order by the read-pointer LSB, using the team's 2-entry permute/depermute helpers. Sits between a 2-wide producer (fetch/decode) and a 2-wide consumer (rename/issue).

---
 rtl/fifo_banked_2w.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/fifo_banked_2w.sv
// Two-wide banked FIFO: 0-2 enqueues and 0-2 dequeues per cycle over two single-write banks.
// Optional simulation checks are enabled with `define FIFO_BANKED_2W_ASSERT_EN.
module fifo_banked_2w #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic [1:0]                   i_enq_valid,
  input  logic [WIDTH-1:0]             i_enq_data [0:1],
  output logic [1:0]                   o_enq_ready,
  output logic [1:0]                   o_deq_valid,
  output logic [WIDTH-1:0]             o_deq_data [0:1],
  input  logic [1:0]                   i_deq_ready,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_empty,
  output logic                         o_full
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = $clog2(DEPTH + 1);
  localparam int ROWS = DEPTH / 2;
  localparam int RW   = PW - 1;

  // Handshake: a lane transfers on the edge where its valid and ready are both high and
  // every lower lane also transfers; ready/valid outputs depend on registered count only.

  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [WIDTH-1:0] bank0 [ROWS];
  logic [WIDTH-1:0] bank1 [ROWS];

  logic [CW-1:0]    free_cnt;
  logic             acc0, acc1, tk0, tk1;
  logic [1:0]       n_enq, n_deq;

  logic [RW-1:0]    wr_row0, wr_row1, rd_row0, rd_row1;
  logic             bank_we0, bank_we1;
  logic [RW-1:0]    bank_wrow0, bank_wrow1;
  logic [WIDTH-1:0] bank_wdata0, bank_wdata1;
  logic [WIDTH-1:0] bank_rdata0, bank_rdata1;

  always_comb begin
    free_cnt       = CW'(DEPTH) - count_q;
    o_enq_ready[0] = (free_cnt != '0);
    o_enq_ready[1] = (free_cnt > CW'(1));
    o_deq_valid[0] = (count_q != '0);
    o_deq_valid[1] = (count_q > CW'(1));
    o_count        = count_q;
    o_empty        = (count_q == '0);
    o_full         = (count_q == CW'(DEPTH));
  end

  // A request of 10 is not contiguous, so lane 1 can never be accepted without lane 0.
  always_comb begin
    acc0  = i_enq_valid[0] & o_enq_ready[0];
    acc1  = acc0 & i_enq_valid[1] & o_enq_ready[1];
    tk0   = i_deq_ready[0] & o_deq_valid[0];
    tk1   = tk0 & i_deq_ready[1] & o_deq_valid[1];
    n_enq = {1'b0, acc0} + {1'b0, acc1};
    n_deq = {1'b0, tk0} + {1'b0, tk1};
  end

  // Lane 1's row is one past lane 0's only when lane 0 sits in bank 1; wraps mod ROWS.
  always_comb begin
    wr_row0 = wr_ptr_q[PW-1:1];
    wr_row1 = wr_ptr_q[0] ? wr_row0 + RW'(1) : wr_row0;
    rd_row0 = rd_ptr_q[PW-1:1];
    rd_row1 = rd_ptr_q[0] ? rd_row0 + RW'(1) : rd_row0;
  end

  // Depermute: lanes to banks, swapped when the write pointer is odd.
  always_comb begin
    if (wr_ptr_q[0]) begin
      bank_we0    = acc1;
      bank_wrow0  = wr_row1;
      bank_wdata0 = i_enq_data[1];
      bank_we1    = acc0;
      bank_wrow1  = wr_row0;
      bank_wdata1 = i_enq_data[0];
    end else begin
      bank_we0    = acc0;
      bank_wrow0  = wr_row0;
      bank_wdata0 = i_enq_data[0];
      bank_we1    = acc1;
      bank_wrow1  = wr_row1;
      bank_wdata1 = i_enq_data[1];
    end
  end

  // Storage is deliberately not reset; flush suppresses writes.
  always_ff @(posedge i_clk) begin
    if (!i_flush) begin
      if (bank_we0) bank0[bank_wrow0] <= bank_wdata0;
      if (bank_we1) bank1[bank_wrow1] <= bank_wdata1;
    end
  end

  // Permute: banks back into program order by the read-pointer LSB.
  always_comb begin
    bank_rdata0 = bank0[rd_ptr_q[0] ? rd_row1 : rd_row0];
    bank_rdata1 = bank1[rd_ptr_q[0] ? rd_row0 : rd_row1];
    if (rd_ptr_q[0]) begin
      o_deq_data[0] = bank_rdata1;
      o_deq_data[1] = bank_rdata0;
    end else begin
      o_deq_data[0] = bank_rdata0;
      o_deq_data[1] = bank_rdata1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (i_flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + PW'(n_enq);
      rd_ptr_q <= rd_ptr_q + PW'(n_deq);
      count_q  <= count_q + CW'(n_enq) - CW'(n_deq);
    end
  end

`ifdef FIFO_BANKED_2W_ASSERT_EN
  if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("fifo_banked_2w: DEPTH must be a power of two and at least 4");
  end

  always @(posedge i_clk) begin
    if (!i_rst) begin
      if (i_enq_valid == 2'b10) $error("fifo_banked_2w: non-contiguous enqueue valid");
      if (i_deq_ready == 2'b10) $error("fifo_banked_2w: non-contiguous dequeue ready");
      if (count_q > CW'(DEPTH)) $error("fifo_banked_2w: count exceeds DEPTH");
      if (({1'b0, count_q} + (CW+1)'(n_enq)) < (CW+1)'(n_deq))
        $error("fifo_banked_2w: count underflow");
    end
  end
`endif

endmodule
